// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-requester RAM arbiter: default widths,
// issue-slot state encoding and requester identifiers.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam logic [0:0] REQ_ID0 = 1'b0;
  localparam logic [0:0] REQ_ID1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both requester command/response channels plus the RAM port.
// master = clients and RAM side, slave = the arbiter.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              r0_valid;
  logic              r0_ready;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_valid;
  logic              r1_ready;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              ram_write_en;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  ram_write_en, ram_read_en, ram_addr, ram_data_in,
    output ram_data_out
  );

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output ram_write_en, ram_read_en, ram_addr, ram_data_in,
    input  ram_data_out
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input grant logic. With RAM_ARB_ROUND_ROBIN_EN defined, ties go to the
// requester not granted last; otherwise fixed priority with r0 winning.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Remembers the last winner; reset to r1 so r0 takes the first tie.
  logic [0:0] last_id;

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      if (last_id == REQ_ID1) gnt = 2'b01;
      else                    gnt = 2'b10;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= REQ_ID1;
    end else if (gnt[1]) begin
      last_id <= REQ_ID1;
    end else if (gnt[0]) begin
      last_id <= REQ_ID0;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk & rst_n;
  assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two valid/ready requesters onto a single-port RAM: accept, issue
// one cycle later, tagged read return one cycle after that. RAM_ARB_ROUND_ROBIN_EN selects round-robin ties.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;
  logic [0:0]        sel_id;

  logic [0:0]        state;
  logic [0:0]        cmd_id;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              issue;
  logic              issue_rd;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;

  logic              r0_rvalid_q;
  logic              r1_rvalid_q;
  logic [DATA_W-1:0] r0_rdata_q;
  logic [DATA_W-1:0] r1_rdata_q;

  // Masking requests with rst_n keeps ready low for the whole reset window.
  assign req = {bus.r1_valid, bus.r0_valid} & {2{rst_n}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.r0_ready = gnt[0];
  assign bus.r1_ready = gnt[1];
  assign accept       = |gnt;
  assign sel_id       = gnt[1] ? REQ_ID1 : REQ_ID0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_id    <= REQ_ID0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (accept) begin
      state     <= ST_ISSUE;
      cmd_id    <= sel_id;
      cmd_we    <= (sel_id == REQ_ID1) ? bus.r1_we    : bus.r0_we;
      cmd_addr  <= (sel_id == REQ_ID1) ? bus.r1_addr  : bus.r0_addr;
      cmd_wdata <= (sel_id == REQ_ID1) ? bus.r1_wdata : bus.r0_wdata;
    end else begin
      state     <= ST_IDLE;
    end
  end

  assign issue    = (state == ST_ISSUE);
  assign issue_rd = issue && !cmd_we;

  always_comb begin
    ram_we = 1'b0;
    ram_re = 1'b0;
    ram_a  = '0;
    ram_d  = '0;
    if (issue) begin
      ram_a = cmd_addr;
      if (cmd_we) begin
        ram_we = 1'b1;
        ram_d  = cmd_wdata;
      end else begin
        ram_re = 1'b1;
      end
    end
  end

  assign bus.ram_write_en = ram_we;
  assign bus.ram_read_en  = ram_re;
  assign bus.ram_addr     = ram_a;
  assign bus.ram_data_in  = ram_d;

  // Read data is captured at the end of the issue cycle and routed by tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      r0_rvalid_q <= issue_rd && (cmd_id == REQ_ID0);
      r1_rvalid_q <= issue_rd && (cmd_id == REQ_ID1);
      if (issue_rd && (cmd_id == REQ_ID0)) r0_rdata_q <= bus.ram_data_out;
      if (issue_rd && (cmd_id == REQ_ID1)) r1_rdata_q <= bus.ram_data_out;
    end
  end

  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed commands push expected read
// returns; a negedge monitor pops and checks tag, data and arrival cycle.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 256x32 RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_data_in;
  assign bus.ram_data_out = mem[bus.ram_addr];

  typedef struct {
    logic        id;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return {bus.r0_ready, bus.r1_ready, bus.r0_rvalid, bus.r1_rvalid,
            bus.r0_rdata, bus.r1_rdata, bus.ram_write_en, bus.ram_read_en,
            bus.ram_addr, bus.ram_data_in};
  endfunction

  // One command cycle: drive after the edge, check grants at negedge, and
  // queue the expected read return two cycles after acceptance.
  task automatic drive(input logic v0, input logic we0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [7:0] a1, input logic [31:0] d1,
                       input logic [1:0] exp_g, input logic [31:0] exp_rd, input logic push,
                       input string name);
    exp_t e;
    @(posedge clk);
    #1;
    bus.r0_valid = v0; bus.r0_we = we0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_valid = v1; bus.r1_we = we1; bus.r1_addr = a1; bus.r1_wdata = d1;
    @(negedge clk);
    check({name, "_ready"}, {126'd0, bus.r1_ready, bus.r0_ready}, {126'd0, exp_g});
    if (push && exp_g != 2'b00 && !(exp_g[1] ? we1 : we0)) begin
      e.id   = exp_g[1];
      e.data = exp_rd;
      e.cyc  = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input string name);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 32'h0, 1'b0, name);
  endtask

  always @(negedge clk) begin
    if (bus.r0_rvalid || bus.r1_rvalid) begin
      if (bus.r0_rvalid && bus.r1_rvalid) begin
        check("rvalid_both", {126'd0, bus.r1_rvalid, bus.r0_rvalid}, 128'd1);
      end else if (sbq.size() == 0) begin
        check("rvalid_unexpected", {126'd0, bus.r1_rvalid, bus.r0_rvalid}, 128'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rv_id", {127'd0, bus.r1_rvalid}, {127'd0, e.id});
        check("rv_data", {96'd0, (bus.r1_rvalid ? bus.r1_rdata : bus.r0_rdata)}, {96'd0, e.data});
        check("rv_cycle", {96'd0, cyc}, {96'd0, e.cyc});
      end
    end
  end

  logic [1:0] t3_g [4];

  initial begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    t3_g[0] = 2'b01; t3_g[1] = 2'b10; t3_g[2] = 2'b01; t3_g[3] = 2'b10;
`else
    t3_g[0] = 2'b01; t3_g[1] = 2'b01; t3_g[2] = 2'b01; t3_g[3] = 2'b01;
`endif
    bus.r0_valid = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_valid = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;

    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 128'd0);
    rst_n = 1'b1;

    // Write then read-back from the same requester.
    drive(1'b1, 1'b1, 8'h05, 32'h12345678, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 32'h0, 1'b1, "wr05");
    drive(1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 32'h12345678, 1'b1, "rd05");

    // r1 writes the top address, r0 reads it on the next cycle.
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'hFF, 32'hDEADBEEF, 2'b10, 32'h0, 1'b1, "wrFF");
    drive(1'b1, 1'b0, 8'hFF, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 32'hDEADBEEF, 1'b1, "rdFF");

    // Preload; the r1 write leaves r1 as last winner so r0 takes the next tie.
    drive(1'b1, 1'b1, 8'h10, 32'hA5A51010, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 32'h0, 1'b1, "wr10");
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h20, 32'h5A5A2020, 2'b10, 32'h0, 1'b1, "wr20");

    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, t3_g[i],
            t3_g[i][1] ? 32'h5A5A2020 : 32'hA5A51010, 1'b1, "tie");

    // Lone r1 request wins immediately even though a tie would favour r0.
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 2'b10, 32'h5A5A2020, 1'b1, "r1_alone");
    idle("idle1");
    check("issue_read_en", {127'd0, bus.ram_read_en}, 128'd1);
    check("issue_addr", {120'd0, bus.ram_addr}, {120'd0, 8'h20});
    idle("idle2");
    check("idle_ram_port", {86'd0, bus.ram_write_en, bus.ram_read_en, bus.ram_addr, bus.ram_data_in}, 128'd0);

    repeat (3) idle("drain");
    check("sb_drain", {96'd0, sbq.size()}, 128'd0);
    check("r0_rdata_hold", {96'd0, bus.r0_rdata}, {96'd0, 32'hA5A51010});
    check("r1_rdata_hold", {96'd0, bus.r1_rdata}, {96'd0, 32'h5A5A2020});

    // Reset lands while a read is in its issue cycle; its return must vanish.
    drive(1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 32'h0, 1'b0, "rd_pre_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_read", all_outputs(), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.r0_valid = 1'b0;
    @(negedge clk);
    check("reset_held", all_outputs(), 128'd0);
    rst_n = 1'b1;
    repeat (4) idle("post_reset");
    check("post_reset_rvalid", {126'd0, bus.r1_rvalid, bus.r0_rvalid}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
